// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the instruction-memory bus, the decode handshake,
// the execute redirect and the branch-predictor update port of fetch_unit.
// master = fetch engine side, slave = memory/decode/execute side.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, if_instr, if_pc, if_pred_taken,
        input  if_ready,
        input  redirect_valid, redirect_pc,
        input  upd_valid, upd_pc, upd_taken
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, if_instr, if_pc, if_pred_taken,
        output if_ready,
        output redirect_valid, redirect_pc,
        output upd_valid, upd_pc, upd_taken
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: registered instruction-fetch engine. One request outstanding at
// a time; the fetched instruction is held for decode until consumed; execute
// redirects override everything and stale responses are drained.
// Optional feature macro: PREDICTOR_EN enables a 2-bit branch history table
// predicting conditional branches, plus JAL target prediction at fetch time.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
    parameter int              BHT_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic            if_pred_taken_q, if_pred_taken_d;
    logic            if_valid_q, if_valid_d;

    logic [XLEN-1:0] redirect_tgt_s;
    logic [XLEN-1:0] seq_pc_s;
    logic [XLEN-1:0] pred_pc_s;
    logic            pred_taken_s;

    assign redirect_tgt_s = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign seq_pc_s       = pc_q + PC_STEP;

`ifdef PREDICTOR_EN
    localparam int         IDX_W      = $clog2(BHT_DEPTH);
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // B-type immediate: byte offset, bit 0 implicitly zero
    function automatic logic [XLEN-1:0] b_imm(input logic [31:0] instr);
        return {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // J-type immediate: byte offset, bit 0 implicitly zero
    function automatic logic [XLEN-1:0] j_imm(input logic [31:0] instr);
        return {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // Saturating 2-bit counter step up (sticks at 3)
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    // Saturating 2-bit counter step down (sticks at 0)
    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [1:0]       bht_d [BHT_DEPTH];
    logic [IDX_W-1:0] lookup_idx_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic [1:0]       lookup_ctr_s;
    logic             unused_s;

    assign lookup_idx_s = pc_q[IDX_W+1:2];
    assign upd_idx_s    = bus.upd_pc[IDX_W+1:2];
    assign lookup_ctr_s = bht_q[lookup_idx_s];
    assign unused_s     = ^{bus.upd_pc[XLEN-1:IDX_W+2], bus.upd_pc[1:0], bus.redirect_pc[1:0]};

    // Next-PC prediction from the instruction arriving this cycle
    always_comb begin
        pred_taken_s = 1'b0;
        pred_pc_s    = seq_pc_s;
        case (bus.imem_rdata[6:0])
            OPC_BRANCH: begin
                if (lookup_ctr_s[1]) begin
                    pred_taken_s = 1'b1;
                    pred_pc_s    = pc_q + b_imm(bus.imem_rdata);
                end else begin
                    pred_taken_s = 1'b0;
                    pred_pc_s    = seq_pc_s;
                end
            end
            OPC_JAL: begin
                pred_taken_s = 1'b1;
                pred_pc_s    = pc_q + j_imm(bus.imem_rdata);
            end
            default: begin
                pred_taken_s = 1'b0;
                pred_pc_s    = seq_pc_s;
            end
        endcase
    end

    // Branch history counter training from resolved branches
    always_comb begin
        bht_d = bht_q;
        if (bus.upd_valid) begin
            if (bus.upd_taken) begin
                bht_d[upd_idx_s] = ctr_inc(bht_q[upd_idx_s]);
            end else begin
                bht_d[upd_idx_s] = ctr_dec(bht_q[upd_idx_s]);
            end
        end else begin
            bht_d = bht_q;
        end
    end

    // Branch history table storage; counters start weakly not-taken
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            bht_q <= bht_d;
        end
    end
`else
    logic unused_s;

    assign pred_taken_s = 1'b0;
    assign pred_pc_s    = seq_pc_s;
    assign unused_s     = ^{bus.upd_valid, bus.upd_pc, bus.upd_taken,
                            bus.redirect_pc[1:0], 9'(BHT_DEPTH)};
`endif

    // Fetch sequencing: redirect first, then the normal request/response flow
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        if_instr_d      = if_instr_q;
        if_pc_d         = if_pc_q;
        if_pred_taken_d = if_pred_taken_q;
        if_valid_d      = if_valid_q;
        if (bus.redirect_valid) begin
            pc_d       = redirect_tgt_s;
            if_valid_d = 1'b0;
            case (state_q)
                ST_FETCH: state_d = bus.imem_gnt    ? ST_DRAIN : ST_FETCH;
                ST_WAIT:  state_d = bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
                ST_HOLD:  state_d = ST_FETCH;
                ST_DRAIN: state_d = bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
                default:  state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_FETCH: state_d = bus.imem_gnt ? ST_WAIT : ST_FETCH;
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if_instr_d      = bus.imem_rdata;
                        if_pc_d         = pc_q;
                        if_pred_taken_d = pred_taken_s;
                        if_valid_d      = 1'b1;
                        pc_d            = pred_pc_s;
                        state_d         = ST_HOLD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (bus.if_ready) begin
                        if_valid_d = 1'b0;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DRAIN: state_d = bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
                default: begin
                    if_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end
            endcase
        end
    end

    // Fetch engine state and decode-facing registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_FETCH;
            pc_q            <= RESET_PC;
            if_instr_q      <= 32'h0000_0000;
            if_pc_q         <= {XLEN{1'b0}};
            if_pred_taken_q <= 1'b0;
            if_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            if_instr_q      <= if_instr_d;
            if_pc_q         <= if_pc_d;
            if_pred_taken_q <= if_pred_taken_d;
            if_valid_q      <= if_valid_d;
        end
    end

    assign bus.imem_req      = (state_q == ST_FETCH);
    assign bus.imem_addr     = pc_q;
    assign bus.if_valid      = if_valid_q;
    assign bus.if_instr      = if_instr_q;
    assign bus.if_pc         = if_pc_q;
    assign bus.if_pred_taken = if_pred_taken_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the RISC-V core. It replaces the bare program counter and PC+4 adder with a registered fetch engine that talks to instruction memory over a request/response handshake. It presents one instruction at a time to decode with a valid/ready handshake and accepts redirects from execute for branches and jumps. An optional 2-bit branch history table predicts conditional branches and JAL targets at fetch time.

## Interface
- XLEN, 32, PC and address width (≥ 32).
- RESET_PC, 0, first fetch address after reset (word aligned).
- BHT_DEPTH, 16, predictor entries; power of two, 4..256.

- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch byte address, bits [1:0] always 0.
- imem_gnt  in  1  request accepted this cycle (imem_req & imem_gnt).
- imem_rvalid  in  1  response valid; at most one outstanding request.
- imem_rdata  in  32  returned instruction.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts this cycle.
- if_instr  out  32  instruction.
- if_pc  out  XLEN  address of if_instr.
- if_pred_taken  out  1  fetch redirected the following PC (prediction or JAL).
- redirect_valid  in  1  execute overrides PC.
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored (treated as 0).
- upd_valid  in  1  resolved conditional branch.
- upd_pc  in  XLEN  address of resolved branch.
- upd_taken  in  1  branch outcome.

## Operation
- Registers: pc, state, if_instr, if_pc, if_pred_taken, if_valid.
- States: FETCH (imem_req=1, imem_addr=pc), WAIT (request accepted, awaiting rvalid), HOLD (if_valid=1 until consumed), DRAIN (discard one stale response).
- FETCH: on gnt → WAIT; otherwise stay.
- WAIT: on rvalid, latch rdata into if_instr and pc into if_pc, set if_valid, compute next pc → HOLD.
- HOLD: on if_valid & if_ready, clear if_valid → FETCH.
- DRAIN: on rvalid, drop the data → FETCH.
- Next PC: pc+4 (mod 2^XLEN). The immediate is a byte offset and gets no extra shift.
- redirect_valid has priority over every other event. pc ← {redirect_pc[XLEN-1:2],2'b00} and if_valid ← 0. Any instruction in HOLD is dropped even if if_ready is high the same cycle.
  - Redirect in FETCH with gnt that cycle, or in WAIT without rvalid → DRAIN.
  - Redirect in WAIT with rvalid that cycle → FETCH; the response is discarded.
  - Redirect in FETCH without gnt, in HOLD, or in DRAIN → FETCH. In DRAIN it goes to FETCH only if rvalid is present that cycle; otherwise it stays in DRAIN.
- imem_rvalid outside WAIT/DRAIN is ignored.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pred_taken=0, all BHT counters=2'b01. imem_req is 1 in the first cycle after reset deasserts.
- Reset asserted mid-transaction: the outstanding response is not tracked. Memory must also be reset.
- Latency with gnt and rvalid at the earliest points:
  - req/gnt at cycle N, rvalid at N+1, if_valid at N+2.
  - Consumption at M gives the next req at M+1.
  - Steady state is one instruction per 3 cycles.
- Redirect at cycle R: imem_addr=redirect target in FETCH at R+1, or at R+1 after the drained response.
- BHT update is written at the clock edge. A same-cycle lookup of the same entry sees the old value.

## Configuration
- PREDICTOR_EN defined:
  - BHT_DEPTH 2-bit saturating counters indexed by pc[log2(BHT_DEPTH)+1:2].
  - In WAIT on rvalid:
    - Opcode 1100011 with counter[1]=1: next pc = pc + B-immediate, if_pred_taken=1.
    - Opcode 1101111 (JAL): next pc = pc + J-immediate, if_pred_taken=1.
  - upd_valid increments the counter at upd_pc's index (taken) or decrements it (not taken), saturating at 3 and 0.
- Undefined: no table, next pc is always pc+4, if_pred_taken is tied to 0, upd_* are ignored.

## Test plan
- Reset with RESET_PC=0x100, memory with zero-wait gnt and 1-cycle rvalid, if_ready=1 → if_pc sequence 0x100, 0x104, 0x108, with if_valid pulses 3 cycles apart.
- if_ready held 0 for 5 cycles → if_valid and if_instr stable, no imem_req asserted, resumes after release.
- redirect_valid with redirect_pc=0x203 while in WAIT → response dropped, next imem_addr=0x200, no if_valid for the stale instruction.
- Redirect in the same cycle as if_valid & if_ready → instruction not counted as delivered, next if_pc=target.
- PREDICTOR_EN, BEQ at 0x10 with offset +0x20: first fetch predicts not-taken (next 0x14). After two upd_taken=1, refetch predicts 0x30 with if_pred_taken=1. JAL at 0x40 offset -8 → next 0x38.
- PREDICTOR_EN undefined, same program → all next addresses pc+4, if_pred_taken always 0.
